// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port RAM between the CPU and a host loader,
// and decodes two CPU-visible I/O words (stdout byte FIFO and a sticky halt flag).
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TXFIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic        i_cpu_req,
  input  logic        i_cpu_wr,
  input  logic [23:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_wait,
  input  logic        i_host_req,
  input  logic        i_host_wr,
  input  logic [23:0] i_host_addr,
  input  logic [31:0] i_host_wdata,
  output logic [31:0] o_host_rdata,
  output logic        o_host_ack,
  output logic        o_ram_cs,
  output logic        o_ram_wr,
  output logic [23:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_halt
);

  localparam int PTR_W = (TXFIFO_DEPTH > 1) ? $clog2(TXFIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(TXFIFO_DEPTH + 1);
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(TXFIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);
  localparam logic [23:0] ADDR_STDOUT = 24'hFFFFFE;
  localparam logic [23:0] ADDR_HALT   = 24'hFFFFFF;

  logic [STV_W-1:0] starve_cnt;
  logic             halt_q;
  logic             cpu_rd_p1;
  logic             cpu_io_p1;
  logic             host_busy_p1;
  logic             host_rd_p1;
  logic [31:0]      io_rdata_p1;
  logic [7:0]       fifo_mem [TXFIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  logic cpu_is_io, host_is_io, cpu_live, cpu_ram, host_elig, host_ram;
  logic forced, grant_host, grant_cpu, fifo_full, stdout_wr, halt_wr;
  logic push, pop;

  // Request decode and grant selection
  always_comb begin
    cpu_is_io  = (i_cpu_addr == ADDR_STDOUT) || (i_cpu_addr == ADDR_HALT);
    host_is_io = (i_host_addr == ADDR_STDOUT) || (i_host_addr == ADDR_HALT);
    cpu_live   = i_cpu_req && !halt_q;
    cpu_ram    = cpu_live && !cpu_is_io;
    // While the host's access is completing (ack cycle) its held request is not re-granted.
    host_elig  = i_host_req && !host_busy_p1;
    host_ram   = host_elig && !host_is_io;
    forced     = (starve_cnt == STARVE_MAX);
    grant_host = host_ram && (!cpu_ram || forced);
    grant_cpu  = cpu_ram && !grant_host;
    fifo_full  = (fifo_cnt == FIFO_FULL);
    stdout_wr  = cpu_live && i_cpu_wr && (i_cpu_addr == ADDR_STDOUT);
    halt_wr    = cpu_live && i_cpu_wr && (i_cpu_addr == ADDR_HALT);
    push       = i_clk_en && stdout_wr && !fifo_full;
    pop        = i_clk_en && o_tx_valid && i_tx_ready;
  end

  assign o_cpu_wait  = (i_cpu_req && halt_q) || (cpu_ram && grant_host) || (stdout_wr && fifo_full);
  assign o_ram_cs    = i_clk_en && (grant_host || grant_cpu);
  assign o_ram_wr    = o_ram_cs && (grant_host ? i_host_wr : i_cpu_wr);
  assign o_ram_addr  = grant_host ? i_host_addr : i_cpu_addr;
  assign o_ram_wdata = grant_host ? i_host_wdata : i_cpu_wdata;

  // Control state: owner registers, starvation counter, halt flag, FIFO pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt   <= '0;
      halt_q       <= 1'b0;
      cpu_rd_p1    <= 1'b0;
      cpu_io_p1    <= 1'b0;
      host_busy_p1 <= 1'b0;
      host_rd_p1   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
    end else if (i_clk_en) begin
      cpu_rd_p1    <= grant_cpu && !i_cpu_wr;
      cpu_io_p1    <= cpu_live && cpu_is_io && !i_cpu_wr;
      host_busy_p1 <= grant_host || (host_elig && host_is_io);
      host_rd_p1   <= grant_host && !i_host_wr;
      if (host_ram && !grant_host)
        starve_cnt <= forced ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
      if (halt_wr)
        halt_q <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push)
        fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Data path: FIFO storage and I/O read value, qualified by the control registers above
  always_ff @(posedge i_clk) begin
    if (i_clk_en) begin
      if (push)
        fifo_mem[wr_ptr] <= i_cpu_wdata[7:0];
      io_rdata_p1 <= (i_cpu_addr == ADDR_STDOUT) ? {{(32-CNT_W){1'b0}}, fifo_cnt}
                                                 : {31'b0, halt_q};
    end
  end

  assign o_cpu_rdata  = cpu_rd_p1 ? i_ram_rdata : (cpu_io_p1 ? io_rdata_p1 : 32'h0);
  assign o_host_rdata = host_rd_p1 ? i_ram_rdata : 32'h0;
  assign o_host_ack   = host_busy_p1 && i_clk_en;
  assign o_tx_data    = fifo_mem[rd_ptr];
  assign o_tx_valid   = (fifo_cnt != '0);
  assign o_halt       = halt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: RAM, arbitration, stdout FIFO, halt, clock enable and reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        cpu_req, cpu_wr;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_wait;
  logic        host_req, host_wr;
  logic [23:0] host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        host_ack;
  logic        ram_cs, ram_wr;
  logic [23:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, halt;

  int compared = 0;
  int mismatched = 0;

  localparam logic [23:0] STDOUT = 24'hFFFFFE;
  localparam logic [23:0] HALT   = 24'hFFFFFF;

  dmem_arbiter #(.STARVE_LIMIT(3), .TXFIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_wait(cpu_wait),
    .i_host_req(host_req), .i_host_wr(host_wr), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_rdata(host_rdata), .o_host_ack(host_ack),
    .o_ram_cs(ram_cs), .o_ram_wr(ram_wr), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_halt(halt)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wr) mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu(input logic req, input logic wr, input logic [23:0] a, input logic [31:0] d);
    cpu_req = req; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic host(input logic req, input logic wr, input logic [23:0] a, input logic [31:0] d);
    host_req = req; host_wr = wr; host_addr = a; host_wdata = d;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; tx_ready = 1'b0;
    cpu(0, 0, 24'h0, 32'h0);
    host(0, 0, 24'h0, 32'h0);
    tick; tick;
    rst = 1'b0; #1;
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_ram_cs", ram_cs, 0);

    // CPU write then read of 0x000010
    cpu(1, 1, 24'h10, 32'h12345678); #1;
    chk("cwr_cs", ram_cs, 1);
    chk("cwr_wr", ram_wr, 1);
    chk("cwr_addr", ram_addr, 32'h10);
    chk("cwr_wdata", ram_wdata, 32'h12345678);
    chk("cwr_wait", cpu_wait, 0);
    tick;
    cpu(1, 0, 24'h10, 32'h0); #1;
    chk("crd_cs", ram_cs, 1);
    chk("crd_wr", ram_wr, 0);
    tick;
    cpu(0, 0, 24'h0, 32'h0); #1;
    chk("crd_data", cpu_rdata, 32'h12345678);
    tick;
    chk("crd_data_clr", cpu_rdata, 32'h0);

    // Host write of 0x000020, CPU idle: immediate grant, ack next cycle
    host(1, 1, 24'h20, 32'hCAFEF00D); #1;
    chk("hwr_cs", ram_cs, 1);
    chk("hwr_wr", ram_wr, 1);
    chk("hwr_addr", ram_addr, 32'h20);
    chk("hwr_ack_early", host_ack, 0);
    tick;
    chk("hwr_ack", host_ack, 1);
    chk("hwr_no_regrant", ram_cs, 0);
    host(0, 0, 24'h0, 32'h0);
    tick;

    // Starvation: CPU reads every cycle, host holds a read
    cpu(1, 0, 24'h10, 32'h0);
    host(1, 0, 24'h20, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("stv_wait", cpu_wait, 0);
      chk("stv_cpu_addr", ram_addr, 32'h10);
      tick;
    end
    #1;
    chk("stv_forced_wait", cpu_wait, 1);
    chk("stv_forced_addr", ram_addr, 32'h20);
    chk("stv_forced_wr", ram_wr, 0);
    tick;
    chk("stv_ack", host_ack, 1);
    chk("stv_rdata", host_rdata, 32'hCAFEF00D);
    chk("stv_wait_after", cpu_wait, 0);
    chk("stv_cpu_back", ram_addr, 32'h10);
    host(0, 0, 24'h0, 32'h0);
    tick;
    chk("stv_ack_clr", host_ack, 0);
    chk("stv_cpu_rdata", cpu_rdata, 32'h12345678);

    // Clock enable low for 3 cycles during a pending host read
    host(1, 0, 24'h20, 32'h0); #1;
    chk("ce_first_wait", cpu_wait, 0);
    tick;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ce_off_cs", ram_cs, 0);
      chk("ce_off_ack", host_ack, 0);
      tick;
    end
    clk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ce_on_wait", cpu_wait, 0);
      chk("ce_on_addr", ram_addr, 32'h10);
      tick;
    end
    #1;
    chk("ce_forced_wait", cpu_wait, 1);
    chk("ce_forced_addr", ram_addr, 32'h20);
    tick;
    chk("ce_ack", host_ack, 1);
    chk("ce_rdata", host_rdata, 32'hCAFEF00D);
    host(0, 0, 24'h0, 32'h0);
    cpu(0, 0, 24'h0, 32'h0);
    tick;

    // Stdout FIFO: fill with 'A'..'D', read occupancy, fifth write stalls
    tx_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu(1, 1, STDOUT, 32'h41 + k); #1;
      chk("fifo_push_wait", cpu_wait, 0);
      chk("fifo_push_cs", ram_cs, 0);
      tick;
    end
    chk("fifo_valid", tx_valid, 1);
    chk("fifo_head", tx_data, 32'h41);
    cpu(1, 0, STDOUT, 32'h0); #1;
    chk("fifo_occ_wait", cpu_wait, 0);
    tick;
    chk("fifo_occ", cpu_rdata, 32'h4);
    cpu(1, 1, STDOUT, 32'h45); #1;
    chk("fifo_full_wait", cpu_wait, 1);
    tick;
    chk("fifo_full_wait2", cpu_wait, 1);
    chk("fifo_full_head", tx_data, 32'h41);
    tx_ready = 1'b1; #1;
    chk("fifo_pop_noblock", cpu_wait, 1);
    tick;
    chk("fifo_unblock", cpu_wait, 0);
    chk("fifo_head_b", tx_data, 32'h42);
    tick;
    cpu(0, 0, 24'h0, 32'h0);
    chk("fifo_head_c", tx_data, 32'h43);
    tick;
    chk("fifo_head_d", tx_data, 32'h44);
    tick;
    chk("fifo_head_e", tx_data, 32'h45);
    chk("fifo_valid_e", tx_valid, 1);
    tick;
    chk("fifo_empty", tx_valid, 0);
    tx_ready = 1'b0;

    // Halt: sticky, CPU stalled, host still served, reset clears it
    cpu(1, 1, HALT, 32'h1); #1;
    chk("halt_wr_wait", cpu_wait, 0);
    chk("halt_wr_cs", ram_cs, 0);
    tick;
    cpu(1, 0, 24'h10, 32'h0); #1;
    chk("halt_set", halt, 1);
    chk("halt_cpu_wait", cpu_wait, 1);
    chk("halt_cpu_cs", ram_cs, 0);
    host(1, 0, 24'h20, 32'h0); #1;
    chk("halt_host_cs", ram_cs, 1);
    chk("halt_host_addr", ram_addr, 32'h20);
    tick;
    chk("halt_host_ack", host_ack, 1);
    chk("halt_host_rdata", host_rdata, 32'hCAFEF00D);
    host(0, 0, 24'h0, 32'h0);
    tick;
    host(1, 0, HALT, 32'h0); #1;
    chk("hio_cs", ram_cs, 0);
    tick;
    chk("hio_ack", host_ack, 1);
    chk("hio_rdata", host_rdata, 32'h0);
    host(0, 0, 24'h0, 32'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0; #1;
    chk("halt_cleared", halt, 0);
    chk("halt_cleared_wait", cpu_wait, 0);
    chk("halt_cleared_cs", ram_cs, 1);
    cpu(0, 0, 24'h0, 32'h0);
    tick;

    // Reset during a granted host read drops the ack; re-issue completes
    host(1, 0, 24'h20, 32'h0); #1;
    chk("rmid_cs", ram_cs, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0; #1;
    chk("rmid_ack_dropped", host_ack, 0);
    chk("rmid_rdata_dropped", host_rdata, 32'h0);
    chk("rmid_reissue_cs", ram_cs, 1);
    tick;
    chk("rmid_reissue_ack", host_ack, 1);
    chk("rmid_reissue_rdata", host_rdata, 32'hCAFEF00D);
    host(0, 0, 24'h0, 32'h0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
